// File: rtl/mux_pkg.sv
// Shared constants and helpers for the mux_arb_nw selector and its arbiter.
//   MODE_FIXED / MODE_RR : values for the MODE parameter of mux_arb_nw
//   idx_width()          : width of a channel index for a given channel count
package mux_pkg;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    // Channel index width; never below one bit so a 1-wide port always exists.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate the request vector so the
// channel at ptr sits at bit 0, pick the lowest set bit, rotate back.
// Ports:
//   req       in   CHANNELS  request per channel
//   ptr       in   IDX_W     highest-priority channel (must be < CHANNELS)
//   grant     out  CHANNELS  one-hot grant, zero when no request
//   grant_idx out  IDX_W     encoded grant, zero when no request
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int unsigned CHANNELS = 4,
    localparam int unsigned IDX_W    = idx_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic [CHANNELS-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx
);

    logic [2*CHANNELS-1:0] dbl_c;
    logic [CHANNELS-1:0]   rot_c;
    logic [IDX_W-1:0]      pos_c;
    logic [IDX_W:0]        sum_c;
    logic                  any_c;

    // Doubling the vector makes the right shift a rotate for any ptr < CHANNELS,
    // including non-power-of-two channel counts.
    always_comb begin
        dbl_c     = {req, req} >> ptr;
        rot_c     = dbl_c[CHANNELS-1:0];
        pos_c     = '0;
        any_c     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        // Downward scan so the lowest rotated position wins.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rot_c[i]) begin
                pos_c = IDX_W'(i);
                any_c = 1'b1;
            end
        end
        // Rotate back: (ptr + pos) mod CHANNELS without a divider.
        sum_c = {1'b0, ptr} + {1'b0, pos_c};
        if (sum_c >= (IDX_W+1)'(CHANNELS)) begin
            sum_c = sum_c - (IDX_W+1)'(CHANNELS);
        end
        if (any_c) begin
            grant_idx        = sum_c[IDX_W-1:0];
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mux_arb_nw.sv
// N-channel registered selector with valid/ready on every input and the
// output. Winner chosen by sel (MODE_FIXED) or round-robin over valid
// channels (MODE_RR), then held in a one-entry output register.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   in_data    CHANNELS*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational from state and inputs)
//   sel        channel select, fixed mode only
//   out_data   registered winner data
//   out_chan   index of the channel held in the output register
//   out_valid  output register occupied
//   out_ready  consumer accepts out_data this cycle
module mux_arb_nw
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned MODE     = MODE_FIXED,
    parameter int unsigned SEL_W    = idx_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SEL_W-1:0]    ptr;
    logic [CHANNELS-1:0] rr_grant_c;
    logic [SEL_W-1:0]    rr_idx_c;
    logic [CHANNELS-1:0] grant_c;
    logic [SEL_W-1:0]    win_idx_c;
    logic [WIDTH-1:0]    win_data_c;
    logic                load_en_c;
    logic                xfer_c;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (rr_grant_c),
        .grant_idx (rr_idx_c)
    );

    // Grant selection; an out-of-range sel grants nothing.
    always_comb begin
        grant_c   = '0;
        win_idx_c = '0;
        if (MODE == MODE_RR) begin
            grant_c   = rr_grant_c;
            win_idx_c = rr_idx_c;
        end else begin
            win_idx_c = sel;
            if (32'(sel) < CHANNELS) begin
                grant_c[sel] = 1'b1;
            end
        end
    end

    // Data mux driven by the one-hot grant.
    always_comb begin
        win_data_c = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant_c[i]) begin
                win_data_c = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load_en_c = !out_valid || out_ready;
    // Ready is forced low during reset since out_valid=0 would otherwise open load_en.
    assign in_ready  = rst ? '0 : ({CHANNELS{load_en_c}} & grant_c);
    assign xfer_c    = |(in_valid & in_ready);

    // Output stage and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else begin
            if (xfer_c) begin
                out_data  <= win_data_c;
                out_chan  <= win_idx_c;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (MODE == MODE_RR && xfer_c) begin
                ptr <= (win_idx_c == SEL_W'(CHANNELS - 1)) ? '0 : win_idx_c + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_nw.sv
// Scoreboard bench for mux_arb_nw: four instances cover fixed/round-robin
// modes with 4 and 3 channels. Stimulus pushes expected words; per-instance
// monitors pop and compare on every output handshake.
module tb_mux_arb_nw;
    import mux_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  chan;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q_f4[$];
    exp_t q_r4[$];
    exp_t q_r3[$];
    exp_t q_f3[$];

    // fixed, 4 channels
    logic [127:0] f4_in_data = '0;
    logic [3:0]   f4_in_valid = '0, f4_in_ready;
    logic [1:0]   f4_sel = '0, f4_out_chan;
    logic [31:0]  f4_out_data;
    logic         f4_out_valid, f4_out_ready = 1'b0;
    // round-robin, 4 channels
    logic [127:0] r4_in_data = '0;
    logic [3:0]   r4_in_valid = '0, r4_in_ready;
    logic [1:0]   r4_sel = '0, r4_out_chan;
    logic [31:0]  r4_out_data;
    logic         r4_out_valid, r4_out_ready = 1'b0;
    // round-robin, 3 channels
    logic [95:0]  r3_in_data = '0;
    logic [2:0]   r3_in_valid = '0, r3_in_ready;
    logic [1:0]   r3_sel = '0, r3_out_chan;
    logic [31:0]  r3_out_data;
    logic         r3_out_valid, r3_out_ready = 1'b0;
    // fixed, 3 channels
    logic [95:0]  f3_in_data = '0;
    logic [2:0]   f3_in_valid = '0, f3_in_ready;
    logic [1:0]   f3_sel = '0, f3_out_chan;
    logic [31:0]  f3_out_data;
    logic         f3_out_valid, f3_out_ready = 1'b0;

    mux_arb_nw #(.WIDTH(32), .CHANNELS(4), .MODE(MODE_FIXED)) u_f4 (
        .clk(clk), .rst(rst), .in_data(f4_in_data), .in_valid(f4_in_valid),
        .in_ready(f4_in_ready), .sel(f4_sel), .out_data(f4_out_data),
        .out_chan(f4_out_chan), .out_valid(f4_out_valid), .out_ready(f4_out_ready));
    mux_arb_nw #(.WIDTH(32), .CHANNELS(4), .MODE(MODE_RR)) u_r4 (
        .clk(clk), .rst(rst), .in_data(r4_in_data), .in_valid(r4_in_valid),
        .in_ready(r4_in_ready), .sel(r4_sel), .out_data(r4_out_data),
        .out_chan(r4_out_chan), .out_valid(r4_out_valid), .out_ready(r4_out_ready));
    mux_arb_nw #(.WIDTH(32), .CHANNELS(3), .MODE(MODE_RR)) u_r3 (
        .clk(clk), .rst(rst), .in_data(r3_in_data), .in_valid(r3_in_valid),
        .in_ready(r3_in_ready), .sel(r3_sel), .out_data(r3_out_data),
        .out_chan(r3_out_chan), .out_valid(r3_out_valid), .out_ready(r3_out_ready));
    mux_arb_nw #(.WIDTH(32), .CHANNELS(3), .MODE(MODE_FIXED)) u_f3 (
        .clk(clk), .rst(rst), .in_data(f3_in_data), .in_valid(f3_in_valid),
        .in_ready(f3_in_ready), .sel(f3_sel), .out_data(f3_out_data),
        .out_chan(f3_out_chan), .out_valid(f3_out_valid), .out_ready(f3_out_ready));

    function automatic exp_t mk(input logic [31:0] d, input logic [3:0] c);
        exp_t e;
        e.data = d;
        e.chan = c;
        return e;
    endfunction

    function automatic logic [31:0] rr_word(input int c);
        return 32'hC0DE_0000 | 32'(c);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic check_word(input string name, input exp_t e,
                              input logic [31:0] d, input logic [3:0] ch);
        n_cmp++;
        if (d !== e.data || ch !== e.chan) begin
            n_bad++;
            $display("FAIL %s word: got data=%h chan=%0d, required data=%h chan=%0d",
                     name, d, ch, e.data, e.chan);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] d, input logic [3:0] ch);
        n_cmp++;
        n_bad++;
        $display("FAIL %s word: got data=%h chan=%0d, required no output", name, d, ch);
    endtask

    // Monitors: pop one expected word per output handshake.
    always @(negedge clk) begin
        if (!rst && f4_out_valid && f4_out_ready) begin
            if (q_f4.size() == 0) unexpected("f4", f4_out_data, 4'(f4_out_chan));
            else check_word("f4", q_f4.pop_front(), f4_out_data, 4'(f4_out_chan));
        end
        if (!rst && r4_out_valid && r4_out_ready) begin
            if (q_r4.size() == 0) unexpected("r4", r4_out_data, 4'(r4_out_chan));
            else check_word("r4", q_r4.pop_front(), r4_out_data, 4'(r4_out_chan));
        end
        if (!rst && r3_out_valid && r3_out_ready) begin
            if (q_r3.size() == 0) unexpected("r3", r3_out_data, 4'(r3_out_chan));
            else check_word("r3", q_r3.pop_front(), r3_out_data, 4'(r3_out_chan));
        end
        if (!rst && f3_out_valid && f3_out_ready) begin
            if (q_f3.size() == 0) unexpected("f3", f3_out_data, 4'(f3_out_chan));
            else check_word("f3", q_f3.pop_front(), f3_out_data, 4'(f3_out_chan));
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_f4_valid", 32'(f4_out_valid), 32'd0);
        check("rst_f4_data", f4_out_data, 32'd0);
        check("rst_r4_chan", 32'(r4_out_chan), 32'd0);
        check("rst_f4_ready", 32'(f4_in_ready), 32'd0);
        next_cycle();
        rst = 1'b0;

        // Fixed select: ch2 only valid, sel=2.
        f4_in_data   = {32'h33333333, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
        f4_in_valid  = 4'b0100;
        f4_sel       = 2'd2;
        f4_out_ready = 1'b1;
        q_f4.push_back(mk(32'hDEADBEEF, 4'd2));
        @(negedge clk);
        check("f4_ready_sel2", 32'(f4_in_ready), 32'h4);
        next_cycle();
        check("f4_valid_after_load", 32'(f4_out_valid), 32'd1);
        check("f4_data_after_load", f4_out_data, 32'hDEADBEEF);
        check("f4_chan_after_load", 32'(f4_out_chan), 32'd2);
        // sel moves to an idle channel: ready without valid, no load, drain.
        f4_sel = 2'd3;
        @(negedge clk);
        check("f4_ready_sel3", 32'(f4_in_ready), 32'h8);
        next_cycle();
        check("f4_drained_valid", 32'(f4_out_valid), 32'd0);
        check("f4_drained_data_hold", f4_out_data, 32'hDEADBEEF);
        check("f4_drained_chan_hold", 32'(f4_out_chan), 32'd2);

        // Backpressure: load ch1 then stall five cycles with churning inputs.
        f4_sel             = 2'd1;
        f4_in_data[63:32]  = 32'hA1A1A1A1;
        f4_in_valid        = 4'b0010;
        f4_out_ready       = 1'b0;
        q_f4.push_back(mk(32'hA1A1A1A1, 4'd1));
        @(negedge clk);
        check("f4_ready_sel1", 32'(f4_in_ready), 32'h2);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            f4_sel            = 2'(k);
            f4_in_valid       = 4'(k + 1);
            f4_in_data[63:32] = 32'h1000 + 32'(k);
            @(negedge clk);
            check("stall_ready", 32'(f4_in_ready), 32'd0);
            check("stall_data", f4_out_data, 32'hA1A1A1A1);
            check("stall_chan", 32'(f4_out_chan), 32'd1);
            check("stall_valid", 32'(f4_out_valid), 32'd1);
            next_cycle();
        end
        // Release: drain and refill on the same edge, no bubble.
        f4_out_ready      = 1'b1;
        f4_sel            = 2'd0;
        f4_in_valid       = 4'b0001;
        f4_in_data[31:0]  = 32'hB0B0B0B0;
        q_f4.push_back(mk(32'hB0B0B0B0, 4'd0));
        @(negedge clk);
        check("release_ready", 32'(f4_in_ready), 32'h1);
        next_cycle();
        check("nobubble_valid", 32'(f4_out_valid), 32'd1);
        check("nobubble_data", f4_out_data, 32'hB0B0B0B0);
        check("nobubble_chan", 32'(f4_out_chan), 32'd0);
        f4_in_valid = 4'b0000;
        repeat (2) next_cycle();
        check("f4_idle_valid", 32'(f4_out_valid), 32'd0);

        // Round-robin, all four valid: 0,1,2,3,0,1,2,3.
        r4_in_data   = {rr_word(3), rr_word(2), rr_word(1), rr_word(0)};
        r4_in_valid  = 4'b1111;
        r4_out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            q_r4.push_back(mk(rr_word(c % 4), 4'(c % 4)));
            @(negedge clk);
            check("r4_ready_all", 32'(r4_in_ready), 32'(1 << (c % 4)));
            next_cycle();
        end
        // Pointer is back at 0; channels 1 and 3 alternate.
        r4_in_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            q_r4.push_back(mk(rr_word((c % 2 == 0) ? 1 : 3), 4'((c % 2 == 0) ? 1 : 3)));
            @(negedge clk);
            check("r4_ready_1010", 32'(r4_in_ready), (c % 2 == 0) ? 32'h2 : 32'h8);
            next_cycle();
        end
        r4_in_valid = 4'b0000;
        repeat (2) next_cycle();
        check("r4_idle_valid", 32'(r4_out_valid), 32'd0);

        // Round-robin, 3 channels: ch2 transfer wraps pointer to 0.
        r3_in_data   = {32'h0000_0C22, 32'h0000_0C11, 32'h0000_0C00};
        r3_in_valid  = 3'b100;
        r3_out_ready = 1'b1;
        q_r3.push_back(mk(32'h0000_0C22, 4'd2));
        @(negedge clk);
        check("r3_ready_ch2", 32'(r3_in_ready), 32'h4);
        next_cycle();
        r3_in_valid = 3'b101;
        q_r3.push_back(mk(32'h0000_0C00, 4'd0));
        @(negedge clk);
        check("r3_ready_wrap_ch0", 32'(r3_in_ready), 32'h1);
        next_cycle();
        q_r3.push_back(mk(32'h0000_0C22, 4'd2));
        @(negedge clk);
        check("r3_ready_then_ch2", 32'(r3_in_ready), 32'h4);
        next_cycle();
        r3_in_valid = 3'b000;
        repeat (2) next_cycle();

        // Fixed, 3 channels, sel out of range: nothing ever loads.
        f3_in_data   = {32'hF3F3_0002, 32'hF3F3_0001, 32'hF3F3_0000};
        f3_in_valid  = 3'b111;
        f3_sel       = 2'd3;
        f3_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("f3_badsel_ready", 32'(f3_in_ready), 32'd0);
            check("f3_badsel_valid", 32'(f3_out_valid), 32'd0);
            next_cycle();
        end
        f3_in_valid = 3'b000;

        // Mid-stream reset with a word stalled in the output register.
        f4_sel            = 2'd2;
        f4_in_data[95:64] = 32'h5A5A5A5A;
        f4_in_valid       = 4'b0100;
        f4_out_ready      = 1'b0;
        next_cycle();
        check("pre_rst_valid", 32'(f4_out_valid), 32'd1);
        check("pre_rst_data", f4_out_data, 32'h5A5A5A5A);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(f4_out_valid), 32'd0);
        check("midrst_data", f4_out_data, 32'd0);
        check("midrst_chan", 32'(f4_out_chan), 32'd0);
        check("midrst_ready", 32'(f4_in_ready), 32'd0);
        f4_in_valid = 4'b0000;
        next_cycle();
        rst = 1'b0;
        repeat (3) next_cycle();
        check("post_rst_valid", 32'(f4_out_valid), 32'd0);
        check("post_rst_ready_sel2", 32'(f4_in_ready), 32'h4);

        check("q_f4_empty", 32'(q_f4.size()), 32'd0);
        check("q_r4_empty", 32'(q_r4.size()), 32'd0);
        check("q_r3_empty", 32'(q_r3.size()), 32'd0);
        check("q_f3_empty", 32'(q_f3.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_arb_nw.md
Name: mux_arb_nw

Overview:
- Parametrised N-channel, W-bit registered selector with valid/ready handshakes on every input and on the output.
- Selects by an explicit select line (fixed mode) or by round-robin arbitration over the valid channels (RR mode).
- Registers the winner into a one-entry output stage.
- Sits between multiple producers (register-file read ports, forwarding sources, memory-response paths) and a single consumer in the miniRISC datapath.

Parameters:
- WIDTH, 32, data width per channel in bits (>=1)
- CHANNELS, 4, number of input channels (2..16)
- MODE, 0, 0 = fixed select via sel, 1 = round-robin among valid channels
- SEL_W, $clog2(CHANNELS), width of sel and out_chan (derived, not overridden)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready (combinational)
- sel  input  SEL_W  channel select, used only when MODE=0
- out_data  output  WIDTH  registered selected data
- out_chan  output  SEL_W  index of the channel held in the output register
- out_valid  output  1  output register holds data
- out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, RR pointer=0. Any in-flight word is discarded; in_ready is all-zero while rst is high.
- load_en = !out_valid || out_ready. The output register accepts a new word only when load_en=1.
- Grant vector is one-hot or zero, and combinational from current inputs and state.
  - MODE=0: grant[i] = (i==sel). If sel >= CHANNELS, grant is zero: no channel ready, no load.
  - MODE=1: grant goes to the first i with in_valid[i]=1, searching ptr, ptr+1, ..., CHANNELS-1, 0, ..., ptr-1 (wraps modulo CHANNELS). If no channel is valid, grant is zero.
- in_ready[i] = load_en && grant[i]. In MODE=0, in_ready[sel] may be 1 while in_valid[sel]=0.
- Transfer on channel k: in_valid[k] && in_ready[k] at a rising edge. On the same edge:
  - out_data <= in_data[k]
  - out_chan <= k
  - out_valid <= 1
- Latency: 1 cycle from input transfer to out_valid. Throughput is 1 word/cycle when out_ready is held high.
- Drain without refill: out_valid && out_ready && no transfer -> out_valid <= 0. out_data and out_chan hold their last values.
- Simultaneous drain and load on the same edge: the new word replaces the old one, out_valid stays 1, no bubble.
- Backpressure: out_valid=1 and out_ready=0 -> all in_ready=0, and the output register holds out_data/out_chan stable.
- RR pointer:
  - Updates only on a transfer: ptr <= (k+1) mod CHANNELS. With CHANNELS not a power of 2, the last channel wraps to 0.
  - Unchanged when there is no transfer or MODE=0.
- A changing sel or in_valid mid-stall has no effect on stored output. The new selection applies at the next load_en cycle.
- Inputs are not required to hold once valid. The block does not check the producer handshake protocol.

Decomposition:
- Shared package mux_pkg:
  - MODE_FIXED=0, MODE_RR=1 constants
  - localparam function for the index width
- Sub-module rr_arbiter:
  - Parameter CHANNELS.
  - Inputs req, ptr. Outputs one-hot grant and encoded grant index.
  - Purely combinational rotate-priority-rotate-back.
- Top-level mux_arb_nw contains the grant mux, the output register and the pointer register.

Test Plan:
- Reset/idle: assert rst mid-stream with out_valid=1 -> out_valid, out_data and out_chan go 0 immediately, in_ready=0000. Release rst with no valid inputs -> out_valid stays 0.
- Fixed select (MODE=0, CHANNELS=4, WIDTH=32):
  - in_data ch2=0xDEADBEEF, in_valid=0100, sel=2, out_ready=1 -> next cycle out_data=0xDEADBEEF, out_chan=2, out_valid=1.
  - Set sel=3 with in_valid=0100 -> in_ready=1000, no load, out_valid drops after drain.
- Round-robin fairness (MODE=1): all four channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,... one per cycle. With in_valid=1010 from ptr=0 -> grants 1,3,1,3.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with changing inputs -> in_ready=0000, out_data constant. Raise out_ready -> the next word loads in the same cycle with no bubble.
- Non-power-of-2 wrap (MODE=1, CHANNELS=3): only ch2 valid, transfer -> ptr wraps to 0. Then ch0 and ch2 valid -> ch0 granted first.
- Invalid select (MODE=0, CHANNELS=3, sel=3): all channels valid -> in_ready=000 and out_valid never asserts.
